// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: opcodes, FSM states,
// datapath mux codes and the bundled control-word type.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_RT      = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SL2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXECUTE   = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_ADDI_EX   = 4'd10,
        S_ADDI_WB   = 4'd11,
        S_HALT      = 4'd15
    } state_e;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       pc_write_cond_ne;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
    } ctrl_t;

    // States that wait on the memory handshake and are guarded by the watchdog.
    function automatic logic is_wait_state(input state_e s);
        return (s == S_FETCH) || (s == S_MEM_READ) || (s == S_MEM_WRITE);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Cycle counter for memory handshake waits; expired flags the last allowed
// wait cycle so the controller can fault on the following edge.
module mem_wait_timer #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    localparam logic [7:0] LAST_COUNT = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] count_q;
    logic [7:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = 8'd0;
        end else if (count_en) begin
            count_d = count_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= 8'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = (count_q == LAST_COUNT);

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS main controller: FETCH/DECODE/EXECUTE/MEM/WB sequencing
// with a memory-ready watchdog and sticky fault flags.
//  state     | meaning
//  FETCH     | read instruction at PC, PC += 4 on mem_ready
//  DECODE    | compute branch target, dispatch on opcode
//  MEM_ADDR  | rs + imm for LW/SW
//  MEM_READ  | wait for load data
//  MEM_WB    | write MDR to rt
//  MEM_WRITE | wait for store completion
//  EXECUTE   | R-type ALU operation
//  R_WB      | write ALUOut to rd
//  BRANCH    | compare, conditional PC load
//  JUMP      | load jump target
//  ADDI_EX   | rs + imm
//  ADDI_WB   | write ALUOut to rt
//  HALT      | stopped until reset
module mips_multicycle_ctrl #(
    parameter int TIMEOUT_CYCLES  = 255,
    parameter int HALT_ON_ILLEGAL = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       pc_write_cond_ne,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic [3:0] state,
    output logic       instr_retired,
    output logic       illegal_op,
    output logic       mem_error,
    output logic       halted
);

    import mips_ctrl_pkg::*;

    state_e state_q;
    state_e state_d;
    logic   illegal_op_q;
    logic   illegal_op_d;
    logic   mem_error_q;
    logic   mem_error_d;
    ctrl_t  ctrl_raw;
    ctrl_t  ctrl_out;
    logic   retire_raw;
    logic   timer_clear;
    logic   timer_count_en;
    logic   timer_expired;
    logic   timeout;

    assign timer_clear    = (state_d != state_q);
    assign timer_count_en = is_wait_state(state_q) && !mem_ready;
    assign timeout        = timer_count_en && timer_expired;

    mem_wait_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_mem_wait_timer (
        .clk      (clk),
        .reset    (reset),
        .clear    (timer_clear),
        .count_en (timer_count_en),
        .expired  (timer_expired)
    );

    always_comb begin
        state_d      = state_q;
        illegal_op_d = illegal_op_q;
        mem_error_d  = mem_error_q;
        ctrl_raw     = '0;
        retire_raw   = 1'b0;

        unique case (state_q)
            S_FETCH: begin
                ctrl_raw.mem_read  = 1'b1;
                ctrl_raw.alu_src_b = SRCB_FOUR;
                ctrl_raw.alu_op    = ALUOP_ADD;
                ctrl_raw.pc_source = PCSRC_ALU;
                ctrl_raw.ir_write  = mem_ready;
                ctrl_raw.pc_write  = mem_ready;
                if (mem_ready) begin
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                ctrl_raw.alu_src_b = SRCB_IMM_SL2;
                ctrl_raw.alu_op    = ALUOP_ADD;
                case (opcode)
                    OP_RTYPE:      state_d = S_EXECUTE;
                    OP_LW, OP_SW:  state_d = S_MEM_ADDR;
                    OP_BEQ, OP_BNE: state_d = S_BRANCH;
                    OP_ADDI:       state_d = S_ADDI_EX;
                    OP_J:          state_d = S_JUMP;
                    default: begin
                        illegal_op_d = 1'b1;
                        state_d      = (HALT_ON_ILLEGAL != 0) ? S_HALT : S_FETCH;
                    end
                endcase
            end
            S_MEM_ADDR: begin
                ctrl_raw.alu_src_a = 1'b1;
                ctrl_raw.alu_src_b = SRCB_IMM;
                ctrl_raw.alu_op    = ALUOP_ADD;
                state_d = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
            end
            S_MEM_READ: begin
                ctrl_raw.mem_read = 1'b1;
                ctrl_raw.i_or_d   = 1'b1;
                if (mem_ready) begin
                    state_d = S_MEM_WB;
                end
            end
            S_MEM_WB: begin
                ctrl_raw.reg_write  = 1'b1;
                ctrl_raw.mem_to_reg = 1'b1;
                state_d    = S_FETCH;
                retire_raw = 1'b1;
            end
            S_MEM_WRITE: begin
                ctrl_raw.mem_write = 1'b1;
                ctrl_raw.i_or_d    = 1'b1;
                if (mem_ready) begin
                    state_d    = S_FETCH;
                    retire_raw = 1'b1;
                end
            end
            S_EXECUTE: begin
                ctrl_raw.alu_src_a = 1'b1;
                ctrl_raw.alu_src_b = SRCB_RT;
                ctrl_raw.alu_op    = ALUOP_FUNCT;
                state_d = S_R_WB;
            end
            S_R_WB: begin
                ctrl_raw.reg_write = 1'b1;
                ctrl_raw.reg_dst   = 1'b1;
                state_d    = S_FETCH;
                retire_raw = 1'b1;
            end
            S_BRANCH: begin
                // IR is stable here, so the opcode still selects BEQ vs BNE.
                ctrl_raw.alu_src_a        = 1'b1;
                ctrl_raw.alu_src_b        = SRCB_RT;
                ctrl_raw.alu_op           = ALUOP_SUB;
                ctrl_raw.pc_source        = PCSRC_ALUOUT;
                ctrl_raw.pc_write_cond    = (opcode == OP_BEQ);
                ctrl_raw.pc_write_cond_ne = (opcode == OP_BNE);
                state_d    = S_FETCH;
                retire_raw = 1'b1;
            end
            S_JUMP: begin
                ctrl_raw.pc_write  = 1'b1;
                ctrl_raw.pc_source = PCSRC_JUMP;
                state_d    = S_FETCH;
                retire_raw = 1'b1;
            end
            S_ADDI_EX: begin
                ctrl_raw.alu_src_a = 1'b1;
                ctrl_raw.alu_src_b = SRCB_IMM;
                ctrl_raw.alu_op    = ALUOP_ADD;
                state_d = S_ADDI_WB;
            end
            S_ADDI_WB: begin
                ctrl_raw.reg_write = 1'b1;
                state_d    = S_FETCH;
                retire_raw = 1'b1;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase

        // A late mem_ready takes priority; only a still-idle memory faults.
        if (timeout) begin
            mem_error_d = 1'b1;
            state_d     = S_HALT;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_FETCH;
            illegal_op_q <= 1'b0;
            mem_error_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            illegal_op_q <= illegal_op_d;
            mem_error_q  <= mem_error_d;
        end
    end

    // Reset masks every output combinationally so an aborted access drops at once.
    assign ctrl_out = reset ? '0 : ctrl_raw;

    assign pc_write         = ctrl_out.pc_write;
    assign pc_write_cond    = ctrl_out.pc_write_cond;
    assign pc_write_cond_ne = ctrl_out.pc_write_cond_ne;
    assign i_or_d           = ctrl_out.i_or_d;
    assign mem_read         = ctrl_out.mem_read;
    assign mem_write        = ctrl_out.mem_write;
    assign ir_write         = ctrl_out.ir_write;
    assign mem_to_reg       = ctrl_out.mem_to_reg;
    assign reg_dst          = ctrl_out.reg_dst;
    assign reg_write        = ctrl_out.reg_write;
    assign alu_src_a        = ctrl_out.alu_src_a;
    assign alu_src_b        = ctrl_out.alu_src_b;
    assign alu_op           = ctrl_out.alu_op;
    assign pc_source        = ctrl_out.pc_source;

    assign state         = reset ? 4'd0 : state_q;
    assign instr_retired = !reset && retire_raw;
    assign illegal_op    = !reset && illegal_op_q;
    assign mem_error     = !reset && mem_error_q;
    assign halted        = !reset && (state_q == S_HALT);

endmodule
